dcpu16_memarb: RTL and testbench



---
 rtl/dcpu16_pkg.sv | 13 +
 rtl/dcpu16_memarb_if.sv | 31 +++
 rtl/dcpu16_spram.sv | 25 ++
 rtl/dcpu16_memarb.sv | 111 +++++++++++
 tb/tb_dcpu16_memarb.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU16 memory arbiter slice.
// State encoding and default RAM address width.
package dcpu16_pkg;

  localparam int unsigned AW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FGNT = 2'd1,
    GGNT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dcpu16_memarb_if.sv
// F-bus (read/write) and G-bus (read-only) simplified Wishbone signals
// between the DCPU16 bus unit (master) and the memory arbiter (slave).
interface dcpu16_memarb_if;

  logic [15:0] f_adr;
  logic        f_stb;
  logic        f_wre;
  logic [15:0] f_dto;
  logic [15:0] f_dti;
  logic        f_ack;

  logic [15:0] g_adr;
  logic        g_stb;
  logic [15:0] g_dti;
  logic        g_ack;

  modport master (
    output f_adr, f_stb, f_wre, f_dto,
    input  f_dti, f_ack,
    output g_adr, g_stb,
    input  g_dti, g_ack
  );

  modport slave (
    input  f_adr, f_stb, f_wre, f_dto,
    output f_dti, f_ack,
    input  g_adr, g_stb,
    output g_dti, g_ack
  );

endinterface

// File: rtl/dcpu16_spram.sv
// Single-port synchronous RAM, 2^AW words x 16 bits, registered
// write-first read: during a write the output shows the new data.
module dcpu16_spram #(
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic [AW-1:0] adr,
  input  logic          wre,
  input  logic [15:0]   dti,
  output logic [15:0]   dto
);

  logic [15:0] mem_r [0:(1<<AW)-1];

  // Memory array write and registered write-first read port.
  always_ff @(posedge clk) begin
    if (wre) begin
      mem_r[adr] <= dti;
      dto        <= dti;
    end else begin
      dto        <= mem_r[adr];
    end
  end

endmodule

// File: rtl/dcpu16_memarb.sv
// Fixed-priority (F over G) arbiter giving the DCPU16 F-bus and G-bus
// one access per cycle to a shared single-port RAM.
module dcpu16_memarb
  import dcpu16_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  dcpu16_memarb_if.slave  bus
);

  arb_state_e    state_r;
  arb_state_e    state_s;
  logic          f_elig_s;
  logic          g_elig_s;
  logic [AW-1:0] ram_adr_s;
  logic          ram_wre_s;
  logic [15:0]   ram_q_s;
  logic          f_ack_r;
  logic          g_ack_r;
  logic          f_rd_r;
  logic          g_rd_r;
  logic [15:0]   f_hold_r;
  logic [15:0]   g_hold_r;

  // Next-state logic; a bus whose ack is high still shows a stale address.
  always_comb begin
    state_s  = IDLE;
    f_elig_s = bus.f_stb & ~f_ack_r;
    g_elig_s = bus.g_stb & ~g_ack_r;
    case (state_r)
      IDLE: begin
        if (f_elig_s) begin
          state_s = FGNT;
        end else if (g_elig_s) begin
          state_s = GGNT;
        end else begin
          state_s = IDLE;
        end
      end
      FGNT, GGNT: begin
        if (g_elig_s && !f_elig_s) begin
          state_s = GGNT;
        end else if (f_elig_s) begin
          state_s = FGNT;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Grant mux: the bus being granted at this edge drives the RAM port.
  always_comb begin
    ram_adr_s = bus.g_adr[AW-1:0];
    ram_wre_s = 1'b0;
    if (rst) begin
      ram_wre_s = 1'b0;
    end else if (state_s == FGNT) begin
      ram_adr_s = bus.f_adr[AW-1:0];
      ram_wre_s = bus.f_wre;
    end else begin
      ram_wre_s = 1'b0;
    end
  end

  dcpu16_spram #(.AW(AW)) u_ram (
    .clk (clk),
    .adr (ram_adr_s),
    .wre (ram_wre_s),
    .dti (bus.f_dto),
    .dto (ram_q_s)
  );

  // State, ack pulses and read-data hold registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      f_ack_r  <= 1'b0;
      g_ack_r  <= 1'b0;
      f_rd_r   <= 1'b0;
      g_rd_r   <= 1'b0;
      f_hold_r <= 16'h0000;
      g_hold_r <= 16'h0000;
    end else begin
      state_r <= state_s;
      f_ack_r <= (state_s == FGNT);
      g_ack_r <= (state_s == GGNT);
      f_rd_r  <= (state_s == FGNT) && !bus.f_wre;
      g_rd_r  <= (state_s == GGNT);
      if (f_rd_r) begin
        f_hold_r <= ram_q_s;
      end
      if (g_rd_r) begin
        g_hold_r <= ram_q_s;
      end
    end
  end

  // The RAM output register carries the data in the ack cycle; afterwards
  // the per-bus hold register keeps it until that bus's next read.
  assign bus.f_dti = f_rd_r ? ram_q_s : f_hold_r;
  assign bus.g_dti = g_rd_r ? ram_q_s : g_hold_r;
  assign bus.f_ack = f_ack_r;
  assign bus.g_ack = g_ack_r;

endmodule

// File: tb/tb_dcpu16_memarb.sv
// Randomized and directed bench for dcpu16_memarb against a cycle-level
// transaction model (priority rule plus an array standing in for the RAM).
module tb_dcpu16_memarb;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcpu16_memarb_if bus ();

  dcpu16_memarb #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ref_mem [DEPTH];
  logic        e_f_ack = 1'b0;
  logic        e_g_ack = 1'b0;
  logic [15:0] e_f_dti = 16'h0000;
  logic [15:0] e_g_dti = 16'h0000;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a * 16'h0101) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] rnd_adr();
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'($urandom_range(63));
    hi = 16'($urandom_range(15));
    return lo | (hi << 12);
  endfunction

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: model decides this cycle's grant, then outputs are compared.
  task automatic cycle();
    logic fe;
    logic ge;
    if (rst) begin
      e_f_ack = 1'b0;
      e_g_ack = 1'b0;
      e_f_dti = 16'h0000;
      e_g_dti = 16'h0000;
    end else begin
      fe = bus.f_stb && !e_f_ack;
      ge = bus.g_stb && !e_g_ack;
      e_f_ack = fe;
      e_g_ack = !fe && ge;
      if (fe) begin
        if (bus.f_wre) ref_mem[bus.f_adr[AW-1:0]] = bus.f_dto;
        else e_f_dti = ref_mem[bus.f_adr[AW-1:0]];
      end else if (ge) begin
        e_g_dti = ref_mem[bus.g_adr[AW-1:0]];
      end
    end
    @(posedge clk);
    #1;
    check_val("f_ack", {15'd0, bus.f_ack}, {15'd0, e_f_ack});
    check_val("g_ack", {15'd0, bus.g_ack}, {15'd0, e_g_ack});
    check_val("f_dti", bus.f_dti, e_f_dti);
    check_val("g_dti", bus.g_dti, e_g_dti);
    check_val("ack_overlap", {15'd0, bus.f_ack & bus.g_ack}, 16'd0);
  endtask

  task automatic f_xfer(input logic [15:0] a, input logic w, input logic [15:0] d);
    int n;
    n = 0;
    bus.f_adr = a;
    bus.f_wre = w;
    bus.f_dto = d;
    bus.f_stb = 1'b1;
    do begin
      cycle();
      n++;
    end while (!bus.f_ack && n < 8);
    check_val("f_xfer_ack", {15'd0, bus.f_ack}, 16'd1);
    bus.f_stb = 1'b0;
  endtask

  initial begin
    bus.f_stb = 1'b0;
    bus.f_wre = 1'b0;
    bus.f_adr = 16'h0000;
    bus.f_dto = 16'h0000;
    bus.g_stb = 1'b0;
    bus.g_adr = 16'h0000;

    rst = 1'b1;
    cycle();
    cycle();
    check_val("rst_f_ack", {15'd0, bus.f_ack}, 16'd0);
    check_val("rst_g_ack", {15'd0, bus.g_ack}, 16'd0);
    check_val("rst_f_dti", bus.f_dti, 16'h0000);
    check_val("rst_g_dti", bus.g_dti, 16'h0000);
    rst = 1'b0;

    for (int a = 0; a < 64; a++) f_xfer(16'(a), 1'b1, pat(16'(a)));
    f_xfer(16'h0010, 1'b1, 16'h7C01);
    cycle();

    // Uncontended read: ack one cycle after the strobe.
    bus.f_adr = 16'h0010;
    bus.f_wre = 1'b0;
    bus.f_stb = 1'b1;
    cycle();
    check_val("rd_lat_ack", {15'd0, bus.f_ack}, 16'd1);
    check_val("rd_data", bus.f_dti, 16'h7C01);
    bus.f_stb = 1'b0;
    cycle();

    // F write then G read of the same word.
    bus.f_adr = 16'h0020;
    bus.f_wre = 1'b1;
    bus.f_dto = 16'hBEEF;
    bus.f_stb = 1'b1;
    cycle();
    check_val("wr_f_ack", {15'd0, bus.f_ack}, 16'd1);
    bus.f_stb = 1'b0;
    bus.g_adr = 16'h0020;
    bus.g_stb = 1'b1;
    cycle();
    check_val("raw_g_ack", {15'd0, bus.g_ack}, 16'd1);
    check_val("raw_g_dti", bus.g_dti, 16'hBEEF);
    check_val("raw_f_dti_kept", bus.f_dti, 16'h7C01);
    bus.g_stb = 1'b0;
    cycle();

    // Simultaneous requests: F first, G one cycle later.
    bus.f_adr = 16'h0001;
    bus.f_wre = 1'b0;
    bus.f_stb = 1'b1;
    bus.g_adr = 16'h0002;
    bus.g_stb = 1'b1;
    cycle();
    check_val("sim_f_ack", {15'd0, bus.f_ack}, 16'd1);
    check_val("sim_g_wait", {15'd0, bus.g_ack}, 16'd0);
    check_val("sim_f_dti", bus.f_dti, pat(16'h0001));
    bus.f_stb = 1'b0;
    cycle();
    check_val("sim_g_ack", {15'd0, bus.g_ack}, 16'd1);
    check_val("sim_f_idle", {15'd0, bus.f_ack}, 16'd0);
    check_val("sim_g_dti", bus.g_dti, pat(16'h0002));
    bus.g_stb = 1'b0;
    cycle();

    // G strobe held across three back-to-back reads.
    bus.g_adr = 16'h0003;
    bus.g_stb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_val("b2b_g_ack", {15'd0, bus.g_ack}, 16'd1);
      check_val("b2b_g_dti", bus.g_dti, pat(16'(3 + k)));
      if (k < 2) begin
        bus.g_adr = 16'(4 + k);
        cycle();
        check_val("b2b_gap", {15'd0, bus.g_ack}, 16'd0);
      end else begin
        bus.g_stb = 1'b0;
      end
    end
    cycle();

    // Upper address bits are ignored with AW=12.
    f_xfer(16'h1003, 1'b0, 16'h0000);
    check_val("wrap_rd", bus.f_dti, pat(16'h0003));
    f_xfer(16'hF007, 1'b1, 16'h1234);
    f_xfer(16'h0007, 1'b0, 16'h0000);
    check_val("wrap_wr", bus.f_dti, 16'h1234);
    cycle();

    // Reset on the grant edge: no ack, then the held strobe is served.
    bus.f_adr = 16'h0005;
    bus.f_wre = 1'b0;
    bus.f_stb = 1'b1;
    rst = 1'b1;
    cycle();
    check_val("rst_drop_ack", {15'd0, bus.f_ack}, 16'd0);
    rst = 1'b0;
    cycle();
    check_val("rst_resume_ack", {15'd0, bus.f_ack}, 16'd1);
    check_val("rst_resume_dti", bus.f_dti, pat(16'h0005));
    bus.f_stb = 1'b0;
    cycle();

    // A write presented on a reset edge must not reach the RAM.
    bus.f_adr = 16'h0006;
    bus.f_wre = 1'b1;
    bus.f_dto = 16'hDEAD;
    bus.f_stb = 1'b1;
    rst = 1'b1;
    cycle();
    bus.f_stb = 1'b0;
    rst = 1'b0;
    cycle();
    f_xfer(16'h0006, 1'b0, 16'h0000);
    check_val("rst_no_write", bus.f_dti, pat(16'h0006));
    cycle();

    // Random traffic from two protocol-abiding masters.
    for (int i = 0; i < 800; i++) begin
      if (!bus.f_stb || bus.f_ack) begin
        if ($urandom_range(3) != 0) begin
          bus.f_stb = 1'b1;
          bus.f_adr = rnd_adr();
          bus.f_wre = 1'($urandom_range(1));
          bus.f_dto = 16'($urandom);
        end else begin
          bus.f_stb = 1'b0;
        end
      end
      if (!bus.g_stb || bus.g_ack) begin
        if ($urandom_range(3) != 0) begin
          bus.g_stb = 1'b1;
          bus.g_adr = rnd_adr();
        end else begin
          bus.g_stb = 1'b0;
        end
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
